// File: rtl/forwarding_scoreboard_pkg.sv
// Shared LC-3b types for the forwarding scoreboard: register ids, the shadow
// pipeline tag and the forwarding select encodings.
package lc3b_types;

    typedef logic [2:0] lc3b_reg;

    typedef struct packed {
        logic    valid;
        lc3b_reg dest;
        logic    load_regfile;
        logic    is_load;
    } fwd_tag_t;

    localparam int FWD_REGFILE    = 0;
    localparam int FWD_STAGE_BASE = 1;

endpackage

// File: rtl/forwarding_scoreboard_fwd_match.sv
// Priority matcher for one source operand: picks the youngest producer stage
// writing the source register and flags a hazard if its data is not ready yet.
module fwd_match
    import lc3b_types::*;
#(
    parameter int NUM_STAGES       = 3,
    parameter int LOAD_READY_STAGE = 2,
    parameter int SEL_W            = $clog2(NUM_STAGES + 1)
) (
    input  fwd_tag_t [NUM_STAGES-1:0] tags,
    input  lc3b_reg                   src_id,
    input  logic                      src_used,
    output logic [SEL_W-1:0]          sel,
    output logic                      hazard
);

    logic             hit   [NUM_STAGES];
    logic             ready [NUM_STAGES];
    logic [SEL_W-1:0] sel_chain [NUM_STAGES+1];
    logic             hz_chain  [NUM_STAGES+1];

    assign sel_chain[NUM_STAGES] = SEL_W'(FWD_REGFILE);
    assign hz_chain[NUM_STAGES]  = 1'b0;

    // Chain runs from the oldest stage towards stage 0, so the youngest hit
    // overrides everything older, even when it can only raise a hazard.
    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            assign hit[gi]   = tags[gi].valid & tags[gi].load_regfile &
                               (tags[gi].dest == src_id);
            assign ready[gi] = ~tags[gi].is_load | (gi >= LOAD_READY_STAGE);

            assign sel_chain[gi] = hit[gi] ? (ready[gi] ? SEL_W'(gi + FWD_STAGE_BASE)
                                                        : SEL_W'(FWD_REGFILE))
                                           : sel_chain[gi+1];
            assign hz_chain[gi]  = hit[gi] ? ~ready[gi] : hz_chain[gi+1];
        end
    endgenerate

    assign sel    = src_used ? sel_chain[0] : SEL_W'(FWD_REGFILE);
    assign hazard = src_used & hz_chain[0];

endmodule

// File: rtl/forwarding_scoreboard.sv
// Forwarding and load-use hazard unit: shadow pipeline of destination tags,
// per-source forwarding selects, load-use stall and a saturating stall counter.
module forwarding_scoreboard
    import lc3b_types::*;
#(
    parameter int NUM_SRC          = 3,
    parameter int NUM_STAGES       = 3,
    parameter int LOAD_READY_STAGE = 2,
    parameter int SEL_W            = $clog2(NUM_STAGES + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           id_valid,
    input  lc3b_reg [NUM_SRC-1:0]          id_src_id,
    input  logic    [NUM_SRC-1:0]          id_src_used,
    input  lc3b_reg                        id_dest,
    input  logic                           id_load_regfile,
    input  logic                           id_is_load,
    input  logic                           pipe_hold,
    input  logic                           flush,
    output logic [NUM_SRC-1:0][SEL_W-1:0]  fwd_sel,
    output logic                           stall,
    output logic [15:0]                    stall_count
);

    fwd_tag_t [NUM_STAGES-1:0] tag_reg;
    fwd_tag_t [NUM_STAGES-1:0] tag_next;
    fwd_tag_t                  id_tag;
    logic     [NUM_SRC-1:0]    hazard;
    logic     [15:0]           stall_count_reg;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            fwd_match #(
                .NUM_STAGES       (NUM_STAGES),
                .LOAD_READY_STAGE (LOAD_READY_STAGE),
                .SEL_W            (SEL_W)
            ) u_match (
                .tags     (tag_reg),
                .src_id   (id_src_id[gi]),
                .src_used (id_src_used[gi]),
                .sel      (fwd_sel[gi]),
                .hazard   (hazard[gi])
            );
        end
    endgenerate

    assign stall = id_valid & ~flush & (|hazard);

    // A stalled or squashed decode instruction enters the pipe as a bubble.
    always_comb begin
        id_tag = '0;
        if (id_valid & ~stall & ~flush) begin
            id_tag.valid        = 1'b1;
            id_tag.dest         = id_dest;
            id_tag.load_regfile = id_load_regfile;
            id_tag.is_load      = id_is_load;
        end
    end

    assign tag_next[0] = id_tag;
    generate
        for (genvar gi = 1; gi < NUM_STAGES; gi++) begin : g_shift
            assign tag_next[gi] = tag_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_reg         <= '0;
            stall_count_reg <= '0;
        end else if (!pipe_hold) begin
            tag_reg <= tag_next;
            if (stall && (stall_count_reg != 16'hFFFF)) begin
                stall_count_reg <= stall_count_reg + 16'd1;
            end
        end
    end

    assign stall_count = stall_count_reg;

endmodule
